// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// A full-subtractor cell with a registered borrow, sequenced by an IDLE/RUN/DONE FSM.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic [1:0]       state_dbg_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bor_q, bor_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             a0, b0, d_bit, bor_next;
  logic [WIDTH-1:0] part_shift;

  assign a0         = a_q[0];
  assign b0         = b_q[0];
  assign d_bit      = a0 ^ b0 ^ bor_q;
  assign bor_next   = (~a0 & b0) | (~(a0 ^ b0) & bor_q);
  assign part_shift = {d_bit, part_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    part_d   = part_q;
    diff_d   = diff_q;
    bor_d    = bor_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start just like IDLE, so operations can run back to back.
        if (start_in) begin
          a_d     = a_in;
          b_d     = b_in;
          part_d  = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        part_d = part_shift;
        bor_d  = bor_next;
        cnt_d  = cnt_q + CW'(1);
        // Result registers update only here, so they hold steady through IDLE and RUN.
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d   = part_shift;
          borrow_d = bor_next;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      diff_q   <= '0;
      bor_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      part_q   <= part_d;
      diff_q   <= diff_d;
      bor_q    <= bor_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_out      = (state_q == RUN);
  assign done_out      = (state_q == DONE);
  assign diff_out      = diff_q;
  assign borrow_out    = borrow_q;
  assign state_dbg_out = state_q;

endmodule
